// File: rtl/sprite_line_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : sprite_line_scheduler_if
// Purpose  : Sprite table read port and bitmap ROM read port shared between
//            the line scheduler (master) and the table/ROM storage (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface sprite_line_scheduler_if #(
    parameter int IDX_W  = 3,
    parameter int CODE_W = 4
);
    logic [IDX_W-1:0]  tbl_idx;
    logic [8:0]        tbl_x;
    logic [8:0]        tbl_y;
    logic [CODE_W-1:0] tbl_code;
    logic [CODE_W+3:0] rom_addr;
    logic [7:0]        rom_data;

    modport master (
        output tbl_idx,
        output rom_addr,
        input  tbl_x,
        input  tbl_y,
        input  tbl_code,
        input  rom_data
    );

    modport slave (
        input  tbl_idx,
        input  rom_addr,
        output tbl_x,
        output tbl_y,
        output tbl_code,
        output rom_data
    );
endinterface
`default_nettype wire

// File: rtl/sprite_line_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sprite_line_scheduler
// Purpose  : Per-scanline sprite scheduler. In horizontal blank it scans the
//            sprite table for the next line and fetches one bitmap row per hit
//            into a small set of line slots; in active video it shifts slot
//            pixels out against hpos and resolves overlaps by slot priority.
// Options  : SPRITE_SCHED_MIRROR_EN - 16-pixel sprites whose right half
//            mirrors the left half of the fetched 8-bit row.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_line_scheduler #(
    parameter int         NUM_SPRITES  = 8,
    parameter int         IDX_W        = 3,
    parameter int         MAX_SLOTS    = 4,
    parameter int         CODE_W       = 4,
    parameter logic [8:0] H_SCAN_START = 9'd320
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [8:0]              hpos,
    input  logic [8:0]              vpos,
    sprite_line_scheduler_if.master bus,
    output logic                    gfx,
    output logic [IDX_W-1:0]        gfx_id,
    output logic                    overflow
);

`ifdef SPRITE_SCHED_MIRROR_EN
    localparam int c_pix_w = 4;
`else
    localparam int c_pix_w = 3;
`endif
    localparam logic [c_pix_w-1:0] c_pix_load = '1;
    localparam int                 c_cnt_w    = $clog2(MAX_SLOTS + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN  = 3'd1,
        FETCH = 3'd2,
        LATCH = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t               r_state;
    logic [IDX_W-1:0]     r_tbl_idx;
    logic [CODE_W+3:0]    r_rom_addr;
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_overflow;
    logic [8:0]           r_cand_x;
    logic [IDX_W-1:0]     r_cand_id;

    logic [MAX_SLOTS-1:0] r_slot_valid;
    logic [7:0]           r_slot_row [MAX_SLOTS];
    logic [8:0]           r_slot_x   [MAX_SLOTS];
    logic [IDX_W-1:0]     r_slot_id  [MAX_SLOTS];

    logic [8:0]           w_dy;
    logic                 w_hit;
    logic                 w_room;
    logic                 w_last;
    logic                 w_scan_start;
    logic                 w_line_start;

    // Row offset of the current entry within its sprite on the next line;
    // modulo-512 wrap lets sprites straddle the top of the frame.
    assign w_dy         = (vpos + 9'd1) - bus.tbl_y;
    assign w_hit        = (w_dy < 9'd16);
    assign w_room       = (r_count < c_cnt_w'(MAX_SLOTS));
    assign w_last       = (r_tbl_idx == IDX_W'(NUM_SPRITES - 1));
    assign w_scan_start = (r_state == IDLE) && (hpos == H_SCAN_START);
    assign w_line_start = (hpos == 9'd0);

    assign bus.tbl_idx  = r_tbl_idx;
    assign bus.rom_addr = r_rom_addr;
    assign overflow     = r_overflow;

    // Table scan / ROM fetch sequencer that fills the line slots in blank.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_tbl_idx    <= '0;
            r_rom_addr   <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_cand_x     <= '0;
            r_cand_id    <= '0;
            r_slot_valid <= '0;
            for (int s = 0; s < MAX_SLOTS; s++) begin
                r_slot_row[s] <= '0;
                r_slot_x[s]   <= '0;
                r_slot_id[s]  <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_scan_start) begin
                        r_state      <= SCAN;
                        r_slot_valid <= '0;
                        r_count      <= '0;
                        r_overflow   <= 1'b0;
                        r_tbl_idx    <= '0;
                    end
                end
                SCAN, FETCH, LATCH: begin
                    if (w_line_start) begin
                        // Out of blank time: keep what was latched, flag the loss.
                        r_state    <= IDLE;
                        r_overflow <= 1'b1;
                    end else if (r_state == SCAN) begin
                        if (w_hit && w_room) begin
                            r_rom_addr <= {bus.tbl_code, w_dy[3:0]};
                            r_cand_x   <= bus.tbl_x;
                            r_cand_id  <= r_tbl_idx;
                            r_state    <= FETCH;
                        end else begin
                            if (w_hit) begin
                                r_overflow <= 1'b1;
                            end
                            if (w_last) begin
                                r_state <= DONE;
                            end else begin
                                r_tbl_idx <= r_tbl_idx + IDX_W'(1);
                                r_state   <= SCAN;
                            end
                        end
                    end else if (r_state == FETCH) begin
                        r_state <= LATCH;
                    end else begin
                        for (int s = 0; s < MAX_SLOTS; s++) begin
                            if (r_count == c_cnt_w'(s)) begin
                                r_slot_row[s]   <= bus.rom_data;
                                r_slot_x[s]     <= r_cand_x;
                                r_slot_id[s]    <= r_cand_id;
                                r_slot_valid[s] <= 1'b1;
                            end
                        end
                        r_count <= r_count + c_cnt_w'(1);
                        if (w_last) begin
                            r_state <= DONE;
                        end else begin
                            r_tbl_idx <= r_tbl_idx + IDX_W'(1);
                            r_state   <= SCAN;
                        end
                    end
                end
                DONE: begin
                    if (w_line_start) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    logic [MAX_SLOTS-1:0] w_slot_on;

    for (genvar s = 0; s < MAX_SLOTS; s++) begin : g_slot
        logic [c_pix_w-1:0] r_pcnt;
        logic               r_run;
        logic               w_load;
        logic [c_pix_w-1:0] w_cur;
        logic [2:0]         w_bit;

        // The counter value for the current column is the loaded value on
        // the start column so the pixel registers one cycle after hpos == x.
        assign w_load = r_slot_valid[s] && (hpos == r_slot_x[s]);
        assign w_cur  = w_load ? c_pix_load : r_pcnt;
`ifdef SPRITE_SCHED_MIRROR_EN
        assign w_bit  = w_cur[3] ? ~w_cur[2:0] : w_cur[2:0];
`else
        assign w_bit  = w_cur;
`endif
        assign w_slot_on[s] = r_slot_valid[s] && (w_load || r_run) && r_slot_row[s][w_bit];

        // Pixel span counter: counts down to zero and holds there.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_pcnt <= '0;
                r_run  <= 1'b0;
            end else if (w_scan_start) begin
                r_pcnt <= '0;
                r_run  <= 1'b0;
            end else begin
                r_pcnt <= (w_cur != '0) ? (w_cur - c_pix_w'(1)) : '0;
                r_run  <= (w_load || r_run) && (w_cur != '0);
            end
        end
    end

    logic             w_any;
    logic [IDX_W-1:0] w_win_id;

    // Lowest slot with a lit pixel wins; the descending walk lets it overwrite.
    always_comb begin
        w_any    = 1'b0;
        w_win_id = '0;
        for (int s = MAX_SLOTS - 1; s >= 0; s--) begin
            if (w_slot_on[s]) begin
                w_any    = 1'b1;
                w_win_id = r_slot_id[s];
            end
        end
    end

    // Registered pixel output; the winner index holds while nothing is lit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gfx    <= 1'b0;
            gfx_id <= '0;
        end else begin
            gfx <= w_any;
            if (w_any) begin
                gfx_id <= w_win_id;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_line_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_line_scheduler
// Purpose  : Self-checking bench for sprite_line_scheduler. Drives a 400
//            column raster, models the table/ROM, and compares every active
//            column against a reference model through a scoreboard queue.
// Options  : SPRITE_SCHED_MIRROR_EN - selects the 16-pixel mirrored model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_line_scheduler;

`ifdef SPRITE_SCHED_MIRROR_EN
    localparam int W = 16;
`else
    localparam int W = 8;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [8:0] hpos  = '0;
    logic [8:0] vpos  = '0;
    logic       gfx;
    logic [2:0] gfx_id;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    sprite_line_scheduler_if #(.IDX_W(3), .CODE_W(4)) bus ();

    sprite_line_scheduler #(
        .NUM_SPRITES (8),
        .IDX_W       (3),
        .MAX_SLOTS   (4),
        .CODE_W      (4),
        .H_SCAN_START(9'd320)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .hpos    (hpos),
        .vpos    (vpos),
        .bus     (bus),
        .gfx     (gfx),
        .gfx_id  (gfx_id),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Sprite table and bitmap ROM
    logic [8:0] tx [8];
    logic [8:0] ty [8];
    logic [3:0] tc [8];
    logic [7:0] rom [256];

    assign bus.tbl_x    = tx[bus.tbl_idx];
    assign bus.tbl_y    = ty[bus.tbl_idx];
    assign bus.tbl_code = tc[bus.tbl_idx];

    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    // Reference model of the slots scanned for the line being displayed
    int         m_n = 0;
    logic [7:0] m_row [4];
    int         m_x   [4];
    logic [2:0] m_id  [4];
    logic [2:0] m_exp_id = '0;

    typedef struct packed {
        logic       g;
        logic [2:0] id;
        logic [8:0] col;
    } exp_t;
    exp_t sb[$];

    // Per-line observations for scenario checks
    logic [7:0] addr_log [400];
    logic       ovf_end;
    int         on_count;
    logic       rst_gfx, rst_ovf;
    logic [2:0] rst_id, rst_idx;
    logic [7:0] rst_addr;

    task automatic clear_table();
        for (int e = 0; e < 8; e++) begin
            tx[e] = 9'd0;
            ty[e] = 9'd300;
            tc[e] = 4'd0;
        end
    endtask

    function automatic void model_capture(input logic [8:0] v);
        logic [8:0] dy;
        m_n = 0;
        for (int e = 0; e < 8; e++) begin
            dy = v + 9'd1 - ty[e];
            if (dy < 9'd16 && m_n < 4) begin
                m_row[m_n] = rom[{tc[e], dy[3:0]}];
                m_x[m_n]   = int'(tx[e]);
                m_id[m_n]  = 3'(e);
                m_n++;
            end
        end
    endfunction

    function automatic void model_pixel(input int h, output logic g, output logic [2:0] id);
        int   k;
        logic b;
        g  = 1'b0;
        id = m_exp_id;
        for (int s = 0; s < m_n; s++) begin
            k = h - m_x[s];
            if (!g && k >= 0 && k < W) begin
                if (W == 16) b = (k < 8) ? m_row[s][k] : m_row[s][15 - k];
                else         b = m_row[s][7 - k];
                if (b) begin
                    g  = 1'b1;
                    id = m_id[s];
                end
            end
        end
        m_exp_id = id;
    endfunction

    // One full raster line; rst_at >= 0 pulses reset low at that column.
    task automatic run_line(input logic [8:0] v, input int rst_at);
        exp_t e;
        logic g;
        logic [2:0] id;
        on_count = 0;
        for (int h = 0; h < 400; h++) begin
            @(negedge clk);
            addr_log[h] = bus.rom_addr;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks += 2;
                if (gfx !== e.g) begin
                    failures++;
                    $display("FAIL gfx line %0d col %0d: got %b expected %b", v, e.col, gfx, e.g);
                end
                if (gfx_id !== e.id) begin
                    failures++;
                    $display("FAIL gfx_id line %0d col %0d: got %0d expected %0d", v, e.col, gfx_id, e.id);
                end
                if (gfx === 1'b1) on_count++;
            end
            if (h == 399) ovf_end = overflow;
            hpos = 9'(h);
            vpos = v;
            if (h < 256) begin
                model_pixel(h, g, id);
                sb.push_back('{g: g, id: id, col: 9'(h)});
            end
            if (h == 320) model_capture(v);
            if (h == rst_at) begin
                reset = 1'b0;
                #1;
                rst_gfx  = gfx;
                rst_ovf  = overflow;
                rst_id   = gfx_id;
                rst_idx  = bus.tbl_idx;
                rst_addr = bus.rom_addr;
                m_n      = 0;
                m_exp_id = '0;
            end
            if (h == rst_at + 2) reset = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks += 5;
        if (gfx !== 1'b0)           begin failures++; $display("FAIL reset_gfx: got %b expected 0", gfx); end
        if (gfx_id !== 3'd0)        begin failures++; $display("FAIL reset_gfx_id: got %0d expected 0", gfx_id); end
        if (overflow !== 1'b0)      begin failures++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        if (bus.tbl_idx !== 3'd0)   begin failures++; $display("FAIL reset_tbl_idx: got %0d expected 0", bus.tbl_idx); end
        if (bus.rom_addr !== 8'h00) begin failures++; $display("FAIL reset_rom_addr: got %0h expected 0", bus.rom_addr); end
        reset = 1'b1;
    endtask

    task automatic test_single();
        clear_table();
        tx[2] = 9'd100; ty[2] = 9'd50; tc[2] = 4'd3;
        run_line(9'd49, -1);
        checks++;
        if (addr_log[324] !== 8'h30) begin failures++; $display("FAIL single_rom_addr: got %0h expected 30", addr_log[324]); end
        run_line(9'd50, -1);
        checks++;
        if (on_count != ((W == 16) ? 4 : 2)) begin failures++; $display("FAIL single_on_count: got %0d expected %0d", on_count, (W == 16) ? 4 : 2); end
    endtask

    task automatic test_vertical_edges();
        logic [7:0] a;
        clear_table();
        tx[0] = 9'd20; ty[0] = 9'd50; tc[0] = 4'd5;
        run_line(9'd64, -1);
        checks++;
        if (addr_log[322] !== 8'h5F) begin failures++; $display("FAIL vedge_row15_addr: got %0h expected 5f", addr_log[322]); end
        run_line(9'd65, -1);
        checks++;
        if (on_count != W) begin failures++; $display("FAIL vedge_row15_on: got %0d expected %0d", on_count, W); end
        run_line(9'd66, -1);
        checks++;
        if (on_count != 0) begin failures++; $display("FAIL vedge_miss_on: got %0d expected 0", on_count); end
        tx[0] = 9'd30; ty[0] = 9'd510; tc[0] = 4'd6;
        run_line(9'd2, -1);
        a = addr_log[322];
        checks++;
        if (a[3:0] !== 4'h5) begin failures++; $display("FAIL vedge_wrap_row: got %0h expected 5", a[3:0]); end
        run_line(9'd3, -1);
    endtask

    task automatic test_overflow();
        clear_table();
        tx[0] = 9'd10;  ty[0] = 9'd100; tc[0] = 4'd1;
        tx[1] = 9'd40;  ty[1] = 9'd100; tc[1] = 4'd2;
        tx[2] = 9'd70;  ty[2] = 9'd86;  tc[2] = 4'd3;
        tx[3] = 9'd100; ty[3] = 9'd86;  tc[3] = 4'd4;
        tx[4] = 9'd130; ty[4] = 9'd86;  tc[4] = 4'd5;
        run_line(9'd100, -1);
        checks++;
        if (ovf_end !== 1'b1) begin failures++; $display("FAIL overflow_set: got %b expected 1", ovf_end); end
        run_line(9'd101, -1);
        checks++;
        if (ovf_end !== 1'b0) begin failures++; $display("FAIL overflow_clear: got %b expected 0", ovf_end); end
        run_line(9'd102, -1);
    endtask

    task automatic test_priority();
        clear_table();
        tx[1] = 9'd200; ty[1] = 9'd150; tc[1] = 4'd7;
        tx[5] = 9'd204; ty[5] = 9'd150; tc[5] = 4'd8;
        run_line(9'd149, -1);
        run_line(9'd150, -1);
        checks += 2;
        if (on_count != W + 4) begin failures++; $display("FAIL priority_span: got %0d expected %0d", on_count, W + 4); end
        if (gfx_id !== 3'd5)   begin failures++; $display("FAIL priority_hold_id: got %0d expected 5", gfx_id); end
    endtask

    task automatic test_reset_mid_scan();
        clear_table();
        tx[0] = 9'd60; ty[0] = 9'd170; tc[0] = 4'd9;
        run_line(9'd169, 322);
        checks += 6;
        if (addr_log[322] !== 8'h90) begin failures++; $display("FAIL midrst_fetch_addr: got %0h expected 90", addr_log[322]); end
        if (rst_gfx !== 1'b0)        begin failures++; $display("FAIL midrst_gfx: got %b expected 0", rst_gfx); end
        if (rst_ovf !== 1'b0)        begin failures++; $display("FAIL midrst_overflow: got %b expected 0", rst_ovf); end
        if (rst_id !== 3'd0)         begin failures++; $display("FAIL midrst_gfx_id: got %0d expected 0", rst_id); end
        if (rst_idx !== 3'd0)        begin failures++; $display("FAIL midrst_tbl_idx: got %0d expected 0", rst_idx); end
        if (rst_addr !== 8'h00)      begin failures++; $display("FAIL midrst_rom_addr: got %0h expected 0", rst_addr); end
        run_line(9'd170, -1);
        checks++;
        if (on_count != 0) begin failures++; $display("FAIL midrst_no_slots: got %0d expected 0", on_count); end
        run_line(9'd171, -1);
        checks++;
        if (on_count != ((W == 16) ? 8 : 4)) begin failures++; $display("FAIL midrst_rescan: got %0d expected %0d", on_count, (W == 16) ? 8 : 4); end
    endtask

    task automatic test_mirror();
        clear_table();
        tx[3] = 9'd40; ty[3] = 9'd200; tc[3] = 4'hA;
        run_line(9'd199, -1);
        run_line(9'd200, -1);
        checks++;
        if (on_count != ((W == 16) ? 2 : 1)) begin failures++; $display("FAIL mirror_on_count: got %0d expected %0d", on_count, (W == 16) ? 2 : 1); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'(i * 91 + 167);
        rom[8'h30] = 8'h81;
        rom[8'h5F] = 8'hFF;
        rom[8'h70] = 8'hFF;
        rom[8'h80] = 8'hFF;
        rom[8'h90] = 8'h3C;
        rom[8'h91] = 8'h3C;
        rom[8'hA0] = 8'h01;
        clear_table();

        test_reset();
        test_single();
        test_vertical_edges();
        test_overflow();
        test_priority();
        test_reset_mid_scan();
        test_mirror();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_line_scheduler.md
Name: sprite_line_scheduler

Overview:
- Per-scanline multi-sprite scheduler that shares one sprite bitmap ROM read port among NUM_SPRITES sprite table entries.
- During horizontal blank it scans the sprite table for the next line and fetches one 8-bit bitmap row per hit into MAX_SLOTS line slots.
- During active video it shifts slot pixels out against hpos and priority-resolves overlaps.
- Sits between hvsync_generator and the rgb mixer in sprite top-levels.

Parameters:
- NUM_SPRITES, 8, sprite table entries scanned per line.
- IDX_W, 3, sprite index width; must satisfy 2^IDX_W >= NUM_SPRITES.
- MAX_SLOTS, 4, sprites displayable on one line.
- CODE_W, 4, bitmap code width; ROM address is {code, row[3:0]}.
- H_SCAN_START, 9'd320, hpos value that starts the table scan; must lie in blank region.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- hpos  in  9  current pixel column from hvsync_generator
- vpos  in  9  current line from hvsync_generator
- tbl_idx  out  IDX_W  sprite table entry being read; reset 0
- tbl_x  in  9  x of entry tbl_idx, combinational same cycle
- tbl_y  in  9  y (top row) of entry tbl_idx, combinational
- tbl_code  in  CODE_W  bitmap code of entry tbl_idx, combinational
- rom_addr  out  CODE_W+4  bitmap ROM address; reset 0
- rom_data  in  8  ROM row, valid one cycle after rom_addr
- gfx  out  1  sprite pixel on, registered; reset 0
- gfx_id  out  IDX_W  table index of winning sprite, registered; reset 0
- overflow  out  1  set when a hit was dropped on last scan; reset 0

Behaviour:
- FSM states: IDLE, SCAN, FETCH, LATCH, DONE. Reset puts FSM in IDLE. Reset also clears all slots, counters, and outputs.
- IDLE -> SCAN when hpos == H_SCAN_START. On entry: all slots invalid, slot count = 0, overflow = 0, tbl_idx = 0.
- SCAN: compute dy = (vpos + 1) - tbl_y, 9-bit modulo 512. Hit when dy < 16; wrap-around is intentional, e.g. y=511, vpos=4 gives dy=6, a hit.
- SCAN, hit, slot count < MAX_SLOTS: rom_addr <= {tbl_code, dy[3:0]}; latch tbl_x and tbl_idx; go to FETCH.
- SCAN, hit, slots full: overflow <= 1; advance to the next entry.
- SCAN, miss: advance to the next entry.
- FETCH: wait one cycle for ROM latency.
- LATCH: write rom_data, x, and index into slot[count]; set slot valid; count++; advance.
- Advance means: if tbl_idx == NUM_SPRITES-1, go to DONE; otherwise tbl_idx++ and return to SCAN.
- Worst case: 3 cycles per entry.
- DONE -> IDLE when hpos == 0.
- Abort: if hpos == 0 is reached in SCAN, FETCH, or LATCH, go to IDLE. Already-latched slots remain displayed; overflow <= 1.
- Slots are written only in blank, so no double buffering.
- Display, per valid slot: when hpos == slot_x, load pixel counter to width-1. Counter decrements to 0 and holds at 0.
- Pixel shown while counter is running (loaded or nonzero-decrementing span).
- Base width is 8: pixel k = row[7-k], MSB first.
- gfx/gfx_id register the lowest-numbered slot with an on pixel. Lower slot = earlier table entry = higher priority.
- Latency: a pixel for column X appears on gfx in the cycle after hpos == X.
- No on pixel in any slot: gfx = 0, gfx_id holds its previous value.
- Slots are invalidated at the next H_SCAN_START.

Optional Feature:
- Macro SPRITE_SCHED_MIRROR_EN.
- When defined: sprite width is 16, counter loads 15. Pixel bit = (cnt >= 8) ? 15 - cnt : cnt. Left half is row bits 0..7; right half mirrors it (symmetric car-style sprites).
- When undefined: width is 8, no mirroring, counter loads 7.

Test Plan:
- Single sprite: entry 2 x=100 y=50 code=3, vpos=49 scan -> rom_addr=0x30 at FETCH; row 0x81 on vpos=50 gives gfx=1 at hpos=100 and hpos=107 (observed next cycle), gfx_id=2, else 0.
- Vertical edges: y=50 with vpos+1=65 gives hit, row 15; vpos+1=66 gives miss. y=510 with vpos+1=3 gives hit, rom_addr low nibble=5.
- Overflow: 5 sprites on the same line, MAX_SLOTS=4 -> entries 0-3 latched, entry 4 dropped, overflow=1. Next line with 2 hits -> overflow=0.
- Priority: entries 1 and 5 overlap at x=200, both rows 0xFF -> gfx_id=1 over the overlap, 5 over entry 5's remaining columns.
- Reset mid-scan: assert reset (low) in FETCH -> gfx=0, overflow=0, FSM in IDLE, no slots valid. Release -> normal scan at next H_SCAN_START.
- Mirror (macro defined): row 0x01, x=40 -> gfx=1 only at columns 40 and 55; 16-pixel span confirmed.
